alu_muldiv_seq: RTL and testbench

//   Multi-cycle sequencer that owns the shared ALU and uses its add/subtract path to run an

---
 rtl/alu_pkg.sv | 23 ++
 rtl/muldiv_shreg.sv | 59 +++++
 rtl/alu_muldiv_seq.sv | 199 +++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU op codes, FSM states, shift-register ops.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB = 4'b0111;
    localparam logic [3:0] ALU_OP_A   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPT,
        ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        SR_HOLD,
        SR_LOAD,
        SR_SHR,
        SR_SHL,
        SR_SET
    } sr_op_e;

endpackage

// File: rtl/muldiv_shreg.sv
// 2*dw-bit {hi,lo} working register: load, right shift with carry-in and new hi, left shift,
// and accept (replace hi, set lo[0]).
module muldiv_shreg
    import alu_pkg::*;
#(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  sr_op_e        op,
    input  logic [dw-1:0] hi_in,
    input  logic [dw-1:0] lo_in,
    input  logic          cin,
    output logic [dw-1:0] hi,
    output logic [dw-1:0] lo
);

    logic [dw-1:0] hi_q, hi_d;
    logic [dw-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op)
            SR_LOAD: begin
                hi_d = hi_in;
                lo_d = lo_in;
            end
            // {cin, hi_in, lo} >> 1: the ALU sum drops one bit into lo
            SR_SHR: begin
                hi_d = {cin, hi_in[dw-1:1]};
                lo_d = {hi_in[0], lo_q[dw-1:1]};
            end
            SR_SHL: begin
                hi_d = {hi_q[dw-2:0], lo_q[dw-1]};
                lo_d = {lo_q[dw-2:0], 1'b0};
            end
            SR_SET: begin
                hi_d = hi_in;
                lo_d = {lo_q[dw-1:1], 1'b1};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply (shift-add) sequencer driving the shared ALU; divide (restoring) is
// present only when MULDIV_DIV_EN is defined.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int dw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rdy,
    input  logic          start,
    input  logic          op_div,
    input  logic [dw-1:0] a,
    input  logic [dw-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [dw-1:0] res_hi,
    output logic [dw-1:0] res_lo,
    output logic          div_zero,
    output logic [3:0]    alu_op,
    output logic [dw-1:0] alu_ai,
    output logic [dw-1:0] alu_bi,
    output logic          alu_ci,
    output logic          alu_right,
    output logic          alu_rotate,
    output logic [3:0]    alu_ei,
    output logic          alu_rdy,
    input  logic [dw-1:0] alu_out,
    input  logic          alu_co
);

    localparam int CW = $clog2(dw) + 1;

`ifdef MULDIV_DIV_EN
    logic div_sel;
    assign div_sel = op_div;
`else
    logic div_sel;
    logic op_div_unused;
    assign div_sel       = 1'b0;
    assign op_div_unused = op_div;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [dw-1:0] m_q, m_d;
    logic          div_q, div_d;
    logic          msb_q, msb_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          div_zero_q, div_zero_d;
    logic [dw-1:0] res_hi_q, res_hi_d;
    logic [dw-1:0] res_lo_q, res_lo_d;

    sr_op_e        sr_op;
    logic [dw-1:0] sr_hi_in, sr_lo_in, sr_hi, sr_lo;
    logic          sr_cin;
    logic [dw-1:0] shl_hi;

    muldiv_shreg #(.dw(dw)) u_shreg (
        .clk   (clk),
        .reset (reset),
        .op    (sr_op),
        .hi_in (sr_hi_in),
        .lo_in (sr_lo_in),
        .cin   (sr_cin),
        .hi    (sr_hi),
        .lo    (sr_lo)
    );

    assign shl_hi = {sr_hi[dw-2:0], sr_lo[dw-1]};

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        m_d        = m_q;
        div_d      = div_q;
        msb_d      = msb_q;
        busy_d     = busy_q;
        done_d     = done_q;
        div_zero_d = div_zero_q;
        res_hi_d   = res_hi_q;
        res_lo_d   = res_lo_q;
        sr_op      = SR_HOLD;
        sr_hi_in   = alu_out;
        sr_lo_in   = b;
        sr_cin     = 1'b0;
        alu_op     = ALU_OP_A;
        alu_ai     = '0;
        alu_bi     = '0;
        alu_ci     = 1'b0;

        // The divide compares against the remainder as it will look after this cycle's left shift
        if (state_q == ST_ISSUE) begin
            alu_bi = m_q;
            if (div_q) begin
                alu_ai = shl_hi;
                alu_ci = 1'b1;
                alu_op = ALU_OP_SUB;
            end else begin
                alu_ai = sr_hi;
                alu_op = sr_lo[0] ? ALU_OP_ADD : ALU_OP_A;
            end
        end

        if (rdy) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_d     = 1'b1;
                        div_zero_d = 1'b0;
                        count_d    = CW'(dw);
                        div_d      = div_sel;
                        m_d        = div_sel ? b : a;
                        sr_op      = SR_LOAD;
                        sr_hi_in   = '0;
                        state_d    = ST_ISSUE;
                        if (div_sel && b == '0) begin
                            sr_hi_in = a;
                            sr_lo_in = '1;
                            state_d  = ST_FIN;
                        end else if (div_sel) begin
                            sr_lo_in = a;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (div_q) begin
                        sr_op = SR_SHL;
                        msb_d = sr_hi[dw-1];
                    end
                    state_d = ST_CAPT;
                end
                ST_CAPT: begin
                    count_d = count_q - CW'(1);
                    if (div_q) begin
                        // a bit shifted out of hi means the partial remainder already exceeds m
                        if (alu_co || msb_q) begin
                            sr_op    = SR_SET;
                            sr_hi_in = alu_out;
                        end
                    end else begin
                        sr_op    = SR_SHR;
                        sr_hi_in = alu_out;
                        sr_cin   = alu_co & sr_lo[0];
                    end
                    state_d = (count_d != '0) ? ST_ISSUE : ST_FIN;
                end
                ST_FIN: begin
                    res_hi_d   = sr_hi;
                    res_lo_d   = sr_lo;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    div_zero_d = div_q && (m_q == '0);
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            m_q        <= '0;
            div_q      <= 1'b0;
            msb_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            res_hi_q   <= '0;
            res_lo_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            m_q        <= m_d;
            div_q      <= div_d;
            msb_q      <= msb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            res_hi_q   <= res_hi_d;
            res_lo_q   <= res_lo_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign res_hi     = res_hi_q;
    assign res_lo     = res_lo_q;
    assign div_zero   = div_zero_q;
    assign alu_rdy    = rdy & busy_q;
    assign alu_right  = 1'b0;
    assign alu_rotate = 1'b0;
    assign alu_ei     = 4'b0000;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq (dw=16) with a behavioural ALU; divide cases need MULDIV_DIV_EN.
module tb_alu_muldiv_seq;

  localparam int DW  = 16;
  localparam int LAT = 2 * DW + 2;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rdy = 1'b1;
  logic          start = 1'b0;
  logic          op_div = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          busy, done, div_zero, alu_ci, alu_right, alu_rotate, alu_rdy;
  logic [DW-1:0] res_hi, res_lo, alu_ai, alu_bi;
  logic [3:0]    alu_op, alu_ei;
  logic [DW-1:0] alu_out_r = '0;
  logic          alu_co_r = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  alu_muldiv_seq #(.dw(DW)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .start(start), .op_div(op_div),
    .a(a), .b(b), .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo),
    .div_zero(div_zero), .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi),
    .alu_ci(alu_ci), .alu_right(alu_right), .alu_rotate(alu_rotate), .alu_ei(alu_ei),
    .alu_rdy(alu_rdy), .alu_out(alu_out_r), .alu_co(alu_co_r)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // behavioural ALU: registers OUT/CO only while alu_rdy
  always @(posedge clk) begin
    if (alu_rdy) begin
      case (alu_op)
        4'b0011: {alu_co_r, alu_out_r} <= {1'b0, alu_ai} + {1'b0, alu_bi} + {16'd0, alu_ci};
        4'b0111: {alu_co_r, alu_out_r} <= {1'b0, alu_ai} + {1'b0, ~alu_bi} + {16'd0, alu_ci};
        default: begin
          alu_out_r <= alu_ai;
          alu_co_r  <= 1'b0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: one transaction at a time, results from plain arithmetic
  bit            m_live = 0, m_active = 0, m_done = 0, m_div = 0, m_dz = 0, p_dz = 0;
  int            m_rem = 0;
  logic [DW-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic [31:0]   prod;

  always @(posedge clk) begin
    m_live = 1;
    if (reset) begin
      m_active = 0; m_done = 0; m_div = 0; m_dz = 0; m_rem = 0;
      m_hi = '0; m_lo = '0;
    end else if (rdy) begin
      m_done = 0;
      if (m_active) begin
        m_rem--;
        if (m_rem == 0) begin
          m_active = 0; m_done = 1;
          m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
        end
      end else if (start) begin
        m_active = 1;
        m_dz = 0;
        m_div = DIV_EN && op_div;
        if (m_div && b == 0) begin
          p_hi = a; p_lo = 16'hFFFF; p_dz = 1; m_rem = 1;
        end else if (m_div) begin
          p_lo = a / b; p_hi = a % b; p_dz = 0; m_rem = LAT - 1;
        end else begin
          prod = 32'(a) * 32'(b);
          p_hi = prod[31:16]; p_lo = prod[15:0]; p_dz = 0; m_rem = LAT - 1;
        end
      end
    end
  end

  // scoreboard compare, every cycle
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("res_hi", res_hi, m_hi);
      chk("res_lo", res_lo, m_lo);
      chk("div_zero", div_zero, m_dz);
      chk("alu_rdy", alu_rdy, rdy & m_active);
      chk("alu_ties", {alu_right, alu_rotate, alu_ei}, 6'd0);
      if (!m_active) begin
        chk("idle_alu_op", alu_op, 4'b1111);
        chk("idle_alu_ai", alu_ai, 16'd0);
        chk("idle_alu_bi", alu_bi, 16'd0);
        chk("idle_alu_ci", alu_ci, 1'b0);
      end else if (!m_div) begin
        chk("mul_no_sub", alu_op == 4'b0111, 1'b0);
      end
    end
  end

  // driver tasks
  task automatic op_start(input logic d, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          output int t0);
    @(posedge clk); #1;
    start = 1'b1; op_div = d; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0 + 1;
        break;
      end
    end
    if (lat < 0) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_lit(input string name, input logic d, input logic [DW-1:0] x,
                         input logic [DW-1:0] y, input logic [DW-1:0] e_hi,
                         input logic [DW-1:0] e_lo, input logic e_dz, input int e_lat);
    int t0, lat;
    op_start(d, x, y, t0);
    wait_done(name, t0, lat);
    chk({name, "_lat"}, lat, e_lat);
    chk({name, "_hi"}, res_hi, e_hi);
    chk({name, "_lo"}, res_lo, e_lo);
    chk({name, "_dz"}, div_zero, e_dz);
  endtask

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000 | 16'($urandom);
      3: return 16'($urandom_range(1, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int t0, lat, n;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_op", alu_op, 4'b1111);

    run_lit("mul_1234x10", 1'b0, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 34);
    run_lit("mul_ffffxffff", 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 34);
`ifdef MULDIV_DIV_EN
    run_lit("div_1000_7", 1'b1, 16'd1000, 16'd7, 16'd6, 16'd142, 1'b0, 34);
    run_lit("div_ffff_8001", 1'b1, 16'hFFFF, 16'h8001, 16'h7FFE, 16'h0001, 1'b0, 34);
    run_lit("div_by_zero", 1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 2);
    run_lit("div_after_zero", 1'b1, 16'd100, 16'd10, 16'd0, 16'd10, 1'b0, 34);
`else
    run_lit("opdiv_ignored", 1'b1, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 34);
`endif

    // stall for 5 cycles mid-run, plus a start pulse while busy
    op_start(1'b0, 16'h00FF, 16'h0101, t0);
    repeat (8) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_alu_rdy", alu_rdy, 1'b0);
      @(posedge clk);
    end
    #1 rdy = 1'b1;
    start = 1'b1; a = 16'h0003; b = 16'h0005;
    @(posedge clk); #1 start = 1'b0;
    wait_done("mul_stall", t0, lat);
    chk("mul_stall_lat", lat, 39);
    chk("mul_stall_hi", res_hi, 16'h0000);
    chk("mul_stall_lo", res_lo, 16'hFFFF);
    n = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("no_extra_done", n, 0);

    // reset at cycle 10 of a multiply
    op_start(1'b0, 16'h1234, 16'h5678, t0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_res_hi", res_hi, 16'h0000);
    chk("abort_res_lo", res_lo, 16'h0000);
    chk("abort_alu_op", alu_op, 4'b1111);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", n, 0);

    // random traffic: stalls, start pulses at any time, occasional reset
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rdy    = ($urandom_range(0, 7) != 0);
      start  = ($urandom_range(0, 9) == 0);
      op_div = 1'($urandom_range(0, 1));
      a      = pick();
      b      = pick();
      reset  = ($urandom_range(0, 999) == 0);
      @(negedge clk);
      if (done) n++;
    end
    @(posedge clk); #1;
    rdy = 1'b1; start = 1'b0; reset = 1'b0;
    repeat (80) @(posedge clk);
    chk("random_completions", n > 20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
